// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box system: controller state codes and the
// playback sub-state encoding.
package musicbox_pkg;

  // System state codes driven by MusicBoxStateController.
  localparam logic [4:0] STATE_DO_NOTHING     = 5'd0;
  localparam logic [4:0] STATE_PLAY_RECORDING = 5'd1;
  localparam logic [4:0] STATE_RECORD         = 5'd2;
  localparam logic [4:0] STATE_PLAY_SONG      = 5'd3;

  // Playback sub-states; the encoding is visible in debugString[26:24].
  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_PRIME  = 3'd1,
    PS_WAIT   = 3'd2,
    PS_PLAY   = 3'd3,
    PS_PAUSED = 3'd4,
    PS_DONE   = 3'd5
  } play_state_t;

endpackage

// File: rtl/musicbox_state_playback.sv
// Recording playback state: streams recording_length samples from the recording
// RAM, one per sample_tick, with pause, abort and loop support. Raises
// stateComplete so the controller can return the system to DoNothing.
module musicbox_state_playback
  import musicbox_pkg::*;
#(
  parameter logic [4:0]  STATE_ID = STATE_PLAY_RECORDING,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                clock_50Mhz,
  input  logic                reset_n,
  input  logic [4:0]          currentState,
  input  logic                sample_tick,
  input  logic [ADDR_W:0]     recording_length,
  input  logic                loop_en,
  input  logic                pause_toggle,
  input  logic                abort,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic                stateComplete,
  output logic [31:0]         debugString
);

  play_state_t         state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     count_inc;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                rd_en_d;
  logic [SAMPLE_W-1:0] audio_d;
  logic                valid_d;
  logic                complete_d;
  logic [31:0]         debug_d;
  logic                last;

  assign count_inc = count_q + 1'b1;
  assign last      = (count_inc == len_q);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    sample_d = sample_q;
    pend_d   = pend_q;
    addr_d   = mem_addr;
    rd_en_d  = 1'b0;
    audio_d  = audio_out;
    valid_d  = 1'b0;

    if (currentState != STATE_ID) begin
      // Leaving the state wins over everything but reset.
      state_d = PS_IDLE;
      len_d   = '0;
      count_d = '0;
      addr_d  = '0;
      audio_d = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          // Fresh entry always restarts at address 0.
          len_d   = recording_length;
          count_d = '0;
          addr_d  = '0;
          audio_d = '0;
          pend_d  = 1'b0;
          if (recording_length == '0) begin
            state_d = PS_DONE;
          end else begin
            rd_en_d = 1'b1;
            state_d = PS_PRIME;
          end
        end
        PS_PRIME: begin
          if (abort) begin
            state_d = PS_DONE;
          end else begin
            state_d = PS_WAIT;
            if (pause_toggle) pend_d = ~pend_q;
          end
        end
        PS_WAIT: begin
          if (abort) begin
            state_d = PS_DONE;
          end else begin
            sample_d = mem_rdata;
            // A toggle recorded during the refill takes effect on arrival.
            state_d  = (pend_q ^ pause_toggle) ? PS_PAUSED : PS_PLAY;
            pend_d   = 1'b0;
          end
        end
        PS_PLAY: begin
          if (abort) begin
            state_d = PS_DONE;
          end else if (sample_tick) begin
            audio_d = sample_q;
            valid_d = 1'b1;
            count_d = count_inc;
            if (last) begin
              // A toggle coinciding with the last sample is dropped.
              pend_d = 1'b0;
              if (loop_en) begin
                count_d = '0;
                addr_d  = '0;
                rd_en_d = 1'b1;
                state_d = PS_PRIME;
              end else begin
                state_d = PS_DONE;
              end
            end else begin
              addr_d  = mem_addr + 1'b1;
              rd_en_d = 1'b1;
              pend_d  = pause_toggle;
              state_d = PS_PRIME;
            end
          end else if (pause_toggle) begin
            state_d = PS_PAUSED;
          end
        end
        PS_PAUSED: begin
          if (abort) begin
            state_d = PS_DONE;
          end else if (pause_toggle) begin
            state_d = PS_PLAY;
          end
        end
        PS_DONE: begin
          audio_d = '0;
        end
        default: begin
          state_d = PS_IDLE;
        end
      endcase
    end

    complete_d = (state_d == PS_DONE);
    debug_d    = {5'b0, state_d, 8'h00, 16'(count_d)};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      state_q       <= PS_IDLE;
      len_q         <= '0;
      count_q       <= '0;
      sample_q      <= '0;
      pend_q        <= 1'b0;
      mem_addr      <= '0;
      mem_rd_en     <= 1'b0;
      audio_out     <= '0;
      audio_valid   <= 1'b0;
      stateComplete <= 1'b0;
      debugString   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      count_q       <= count_d;
      sample_q      <= sample_d;
      pend_q        <= pend_d;
      mem_addr      <= addr_d;
      mem_rd_en     <= rd_en_d;
      audio_out     <= audio_d;
      audio_valid   <= valid_d;
      stateComplete <= complete_d;
      debugString   <= debug_d;
    end
  end

endmodule

// File: tb/tb_musicbox_state_playback.sv
// Directed bench for musicbox_state_playback with a one-cycle-latency RAM model.
module tb_musicbox_state_playback;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned SAMPLE_W = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [4:0]          current_state;
  logic                sample_tick;
  logic [ADDR_W:0]     recording_length;
  logic                loop_en;
  logic                pause_toggle;
  logic                abort;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd_en;
  logic [SAMPLE_W-1:0] mem_rdata = '0;
  logic [SAMPLE_W-1:0] audio_out;
  logic                audio_valid;
  logic                state_complete;
  logic [31:0]         debug_string;

  logic [SAMPLE_W-1:0] ram [2**ADDR_W];
  int                  audio_log[$];
  int                  addr_log[$];
  bit                  saw_complete;
  int                  n_checks = 0;
  int                  n_pass   = 0;

  musicbox_state_playback #(
    .STATE_ID (5'd1),
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .clock_50Mhz      (clk),
    .reset_n          (reset_n),
    .currentState     (current_state),
    .sample_tick      (sample_tick),
    .recording_length (recording_length),
    .loop_en          (loop_en),
    .pause_toggle     (pause_toggle),
    .abort            (abort),
    .mem_addr         (mem_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_rdata        (mem_rdata),
    .audio_out        (audio_out),
    .audio_valid      (audio_valid),
    .stateComplete    (state_complete),
    .debugString      (debug_string)
  );

  always #5 clk = ~clk;

  // RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en === 1'b1) mem_rdata <= ram[mem_addr];

  // Log emitted samples, issued reads and completion, sampled on the falling edge.
  always @(negedge clk) begin
    if (audio_valid === 1'b1)    audio_log.push_back(int'(audio_out));
    if (mem_rd_en === 1'b1)      addr_log.push_back(int'(mem_addr));
    if (state_complete === 1'b1) saw_complete = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic leave();
    current_state = 5'd0;
    loop_en       = 1'b0;
    step(2);
    audio_log.delete();
    addr_log.delete();
    saw_complete = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check({tag, "_count"}, audio_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check(tag, (i < audio_log.size()) ? audio_log[i] : 32'hffff_ffff, exp[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = SAMPLE_W'(i + 10);
    reset_n          = 1'b0;
    current_state    = 5'd0;
    sample_tick      = 1'b0;
    recording_length = '0;
    loop_en          = 1'b0;
    pause_toggle     = 1'b0;
    abort            = 1'b0;
    saw_complete     = 1'b0;
    step(3);
    check("rst_audio", 32'(audio_out), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_complete", 32'(state_complete), 0);
    check("rst_debug", debug_string, 0);
    reset_n = 1'b1;
    step(1);

    // len=4 straight playback.
    recording_length = 15'd4;
    current_state    = 5'd1;
    step(5);
    for (int t = 0; t < 4; t++) begin
      tick();
      if (t < 3) step(9);
    end
    check("l4_complete_at_tick", 32'(state_complete), 1);
    check("l4_last_audio", 32'(audio_out), 13);
    check("l4_last_valid", 32'(audio_valid), 1);
    step(2);
    check("l4_done_audio", 32'(audio_out), 0);
    check("l4_debug", debug_string, 32'h0500_0004);
    check_seq("l4_audio", '{10, 11, 12, 13});
    check("l4_reads", addr_log.size(), 4);
    check("l4_addr3", (addr_log.size() > 3) ? addr_log[3] : -1, 3);

    // len=0: complete without any read.
    leave();
    recording_length = 15'd0;
    current_state    = 5'd1;
    step(2);
    check("l0_complete", 32'(state_complete), 1);
    check("l0_reads", addr_log.size(), 0);
    check("l0_debug", debug_string, 32'h0500_0000);

    // len=3 looping, 7 ticks.
    leave();
    recording_length = 15'd3;
    loop_en          = 1'b1;
    current_state    = 5'd1;
    step(5);
    for (int t = 0; t < 7; t++) begin
      tick();
      step(9);
    end
    check_seq("loop_audio", '{10, 11, 12, 10, 11, 12, 10});
    check("loop_no_complete", 32'(saw_complete), 0);
    check("loop_reads", addr_log.size(), 8);
    check("loop_debug", debug_string, 32'h0300_0001);

    // len=5 pause, ignored ticks, resume, abort.
    leave();
    recording_length = 15'd5;
    current_state    = 5'd1;
    step(5);
    tick();
    step(9);
    tick();
    step(9);
    pause_toggle = 1'b1;
    step(1);
    pause_toggle = 1'b0;
    check("pause_debug", debug_string, 32'h0400_0002);
    for (int t = 0; t < 3; t++) begin
      tick();
      step(9);
    end
    check("pause_held", 32'(audio_out), 11);
    check("pause_no_emit", audio_log.size(), 2);
    pause_toggle = 1'b1;
    step(1);
    pause_toggle = 1'b0;
    check("resume_debug", debug_string, 32'h0300_0002);
    step(3);
    tick();
    check("resume_audio", 32'(audio_out), 12);
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_complete", 32'(state_complete), 1);
    check("abort_debug", debug_string, 32'h0500_0003);
    step(1);
    check("abort_audio", 32'(audio_out), 0);
    check_seq("pause_audio", '{10, 11, 12});

    // len=8, exit after the 2nd tick, then re-entry.
    leave();
    recording_length = 15'd8;
    current_state    = 5'd1;
    step(5);
    tick();
    step(9);
    tick();
    step(3);
    current_state = 5'd0;
    step(1);
    check("exit_audio", 32'(audio_out), 0);
    check("exit_addr", 32'(mem_addr), 0);
    check("exit_complete", 32'(state_complete), 0);
    check("exit_debug", debug_string, 0);
    audio_log.delete();
    addr_log.delete();
    current_state = 5'd1;
    step(5);
    check("reentry_reads", addr_log.size(), 1);
    check("reentry_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);
    tick();
    check("reentry_audio", 32'(audio_out), 10);

    // Reset mid-PLAY, then tick together with pause_toggle.
    step(9);
    tick();
    step(3);
    reset_n = 1'b0;
    step(1);
    check("midrst_audio", 32'(audio_out), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_valid", 32'(audio_valid), 0);
    check("midrst_debug", debug_string, 0);
    reset_n = 1'b1;
    audio_log.delete();
    step(5);
    sample_tick  = 1'b1;
    pause_toggle = 1'b1;
    step(1);
    sample_tick  = 1'b0;
    pause_toggle = 1'b0;
    check("tickpause_audio", 32'(audio_out), 10);
    step(3);
    check("tickpause_debug", debug_string, 32'h0400_0001);
    tick();
    step(9);
    check("tickpause_ignored", audio_log.size(), 1);

    leave();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
